// File: rtl/video_timing_ctrl.sv
// Programmable raster timing generator for the TMDS pixel path. Timing registers are
// double-buffered and committed atomically on the last pixel of a frame.
module video_timing_ctrl #(
    parameter int W          = 11,
    parameter int H_ACTIVE_D = 640,
    parameter int H_SS_D     = 656,
    parameter int H_SE_D     = 752,
    parameter int H_TOTAL_D  = 800,
    parameter int V_ACTIVE_D = 480,
    parameter int V_SS_D     = 490,
    parameter int V_SE_D     = 492,
    parameter int V_TOTAL_D  = 525
) (
    input  logic         pixclk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [W-1:0] cfg_wdata,
    input  logic         cfg_commit,
    output logic         cfg_busy,
    output logic         cfg_err,
    output logic [W-1:0] CounterX,
    output logic [W-1:0] CounterY,
    output logic         hSync,
    output logic         vSync,
    output logic         DrawArea,
    output logic         frame_start
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PEND} state_e;

    // Register file index: 0-3 horizontal (active, sync start, sync end, total), 4-7 vertical.
    localparam int R_HA = 0, R_HSS = 1, R_HSE = 2, R_HT = 3;
    localparam int R_VA = 4, R_VSS = 5, R_VSE = 6, R_VT = 7;

    state_e       state_q, state_d;
    logic [W-1:0] shadow_q [8];
    logic [W-1:0] shadow_d [8];
    logic [W-1:0] active_q [8];
    logic [W-1:0] active_d [8];
    logic [2:0]   ctrl_q, ctrl_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic         hsync_q, hsync_d, vsync_q, vsync_d;
    logic         draw_q, draw_d, fstart_q, fstart_d, err_q, err_d;
    logic         shadow_valid, last_x, last_y, live, in_hsync, in_vsync;

    function automatic logic [W-1:0] reg_default(input int idx);
        case (idx)
            R_HA:    reg_default = W'(H_ACTIVE_D);
            R_HSS:   reg_default = W'(H_SS_D);
            R_HSE:   reg_default = W'(H_SE_D);
            R_HT:    reg_default = W'(H_TOTAL_D);
            R_VA:    reg_default = W'(V_ACTIVE_D);
            R_VSS:   reg_default = W'(V_SS_D);
            R_VSE:   reg_default = W'(V_SE_D);
            default: reg_default = W'(V_TOTAL_D);
        endcase
    endfunction

    function automatic logic axis_ok(input logic [W-1:0] act, input logic [W-1:0] ss,
                                     input logic [W-1:0] se, input logic [W-1:0] tot);
        return (act != '0) && (act < ss) && (ss < se) && (se <= tot);
    endfunction

    always_comb begin
        // NOTE: every variable is given a default first so no path can infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        ctrl_d   = ctrl_q;
        x_d      = x_q;
        y_d      = y_q;
        err_d    = 1'b0;

        if (cfg_we && (cfg_addr == 4'd8)) ctrl_d = cfg_wdata[2:0];
        if (cfg_we && !cfg_addr[3] && (state_q != ST_PEND)) shadow_d[cfg_addr[2:0]] = cfg_wdata;

        // A commit issued together with a write is judged on the post-write set.
        shadow_valid = axis_ok(shadow_d[R_HA], shadow_d[R_HSS], shadow_d[R_HSE], shadow_d[R_HT])
                    && axis_ok(shadow_d[R_VA], shadow_d[R_VSS], shadow_d[R_VSE], shadow_d[R_VT]);

        last_x = (x_q == active_q[R_HT] - W'(1));
        last_y = (y_q == active_q[R_VT] - W'(1));

        if (state_q != ST_IDLE) begin
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_q + W'(1);
            end else begin
                x_d = x_q + W'(1);
            end
        end

        case (state_q)
            ST_IDLE: if (ctrl_d[0]) state_d = ST_RUN;
            ST_RUN: begin
                if (cfg_commit) begin
                    if (shadow_valid) state_d = ST_PEND;
                    else              err_d   = 1'b1;
                end
            end
            ST_PEND: begin
                if (last_x && last_y) begin
                    active_d = shadow_q;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Disabling wins over everything: counters clear and a pending commit is dropped.
        if (!ctrl_d[0]) begin
            state_d  = ST_IDLE;
            x_d      = '0;
            y_d      = '0;
            active_d = active_q;
            err_d    = 1'b0;
        end

        live     = (state_q != ST_IDLE) && (state_d != ST_IDLE);
        in_hsync = (x_q >= active_q[R_HSS]) && (x_q < active_q[R_HSE]);
        in_vsync = (y_q >= active_q[R_VSS]) && (y_q < active_q[R_VSE]);
        draw_d   = live && (x_q < active_q[R_HA]) && (y_q < active_q[R_VA]);
        fstart_d = live && (x_q == '0) && (y_q == '0);
        hsync_d  = live ? (in_hsync ~^ ctrl_d[1]) : ~ctrl_d[1];
        vsync_d  = live ? (in_vsync ~^ ctrl_d[2]) : ~ctrl_d[2];
    end

    always_ff @(posedge pixclk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            // NOTE: the timing register files must wake up holding a usable raster, so they are reset like ordinary flops.
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= reg_default(i);
                active_q[i] <= reg_default(i);
            end
            state_q  <= ST_RUN;
            ctrl_q   <= 3'b001;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            draw_q   <= 1'b0;
            fstart_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            draw_q   <= draw_d;
            fstart_q <= fstart_d;
            err_q    <= err_d;
        end
    end

    assign cfg_busy    = (state_q == ST_PEND);
    assign cfg_err     = err_q;
    assign CounterX    = x_q;
    assign CounterY    = y_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign DrawArea    = draw_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Randomised and directed bench for video_timing_ctrl, checked against a pixel-index
// reference model; a second instance with factory defaults checks the 640x480 raster.
module tb_video_timing_ctrl;

    localparam int W   = 11;
    localparam int HA  = 16, HSS = 18, HSE = 22, HT = 26;
    localparam int VA  = 6,  VSS = 7,  VSE = 9,  VT = 10;

    logic         pixclk = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [W-1:0] cfg_wdata = '0;
    logic         cfg_commit = 1'b0;
    logic         cfg_busy, cfg_err, hSync, vSync, DrawArea, frame_start;
    logic [W-1:0] CounterX, CounterY;

    logic         d_busy, d_err, d_hs, d_vs, d_draw, d_fs;
    logic [W-1:0] d_x, d_y;

    video_timing_ctrl #(
        .W(W), .H_ACTIVE_D(HA), .H_SS_D(HSS), .H_SE_D(HSE), .H_TOTAL_D(HT),
        .V_ACTIVE_D(VA), .V_SS_D(VSS), .V_SE_D(VSE), .V_TOTAL_D(VT)
    ) dut (
        .pixclk(pixclk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
        .cfg_err(cfg_err), .CounterX(CounterX), .CounterY(CounterY), .hSync(hSync),
        .vSync(vSync), .DrawArea(DrawArea), .frame_start(frame_start)
    );

    video_timing_ctrl dut_def (
        .pixclk(pixclk), .reset(reset), .cfg_we(1'b0), .cfg_addr(4'd0),
        .cfg_wdata(11'd0), .cfg_commit(1'b0), .cfg_busy(d_busy),
        .cfg_err(d_err), .CounterX(d_x), .CounterY(d_y), .hSync(d_hs),
        .vSync(d_vs), .DrawArea(d_draw), .frame_start(d_fs)
    );

    always #5 pixclk = ~pixclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position is a single pixel index within the frame.
    int m_sh[8];
    int m_act[8];
    int def_cfg[8] = '{HA, HSS, HSE, HT, VA, VSS, VSE, VT};
    bit m_en, m_hpol, m_vpol, m_pend, m_hs, m_vs, m_draw, m_fs, m_err;
    int m_pix;

    typedef struct {
        logic [3:0] a;
        int         d;
    } wr_t;

    function automatic logic [27:0] dut_vec();
        return {CounterX, CounterY, hSync, vSync, DrawArea, frame_start, cfg_busy, cfg_err};
    endfunction

    function automatic logic [27:0] model_vec();
        int x, y;
        x = m_pix % m_act[3];
        y = m_pix / m_act[3];
        return {W'(x), W'(y), m_hs, m_vs, m_draw, m_fs, m_pend, m_err};
    endfunction

    function automatic bit axis_ok(input int a, input int ss, input int se, input int t);
        return (a >= 1) && (a < ss) && (ss < se) && (se <= t);
    endfunction

    task automatic model_reset();
        m_sh = def_cfg;
        m_act = def_cfg;
        m_en = 1; m_hpol = 0; m_vpol = 0; m_pend = 0; m_pix = 0;
        m_hs = 0; m_vs = 0; m_draw = 0; m_fs = 0; m_err = 0;
    endtask

    task automatic model_step(input bit we, input logic [3:0] addr, input int data, input bit commit);
        int htot, x, y;
        bit new_en, new_hp, new_vp, live, was_pend, last;
        htot = m_act[3];
        x = m_pix % htot;
        y = m_pix / htot;
        new_en = m_en; new_hp = m_hpol; new_vp = m_vpol;
        if (we && addr == 4'd8) begin
            new_en = data[0]; new_hp = data[1]; new_vp = data[2];
        end
        live   = m_en && new_en;
        m_draw = live && (x < m_act[0]) && (y < m_act[4]);
        m_hs   = live ? (((x >= m_act[1]) && (x < m_act[2])) == new_hp) : !new_hp;
        m_vs   = live ? (((y >= m_act[5]) && (y < m_act[6])) == new_vp) : !new_vp;
        m_fs   = live && (m_pix == 0);
        m_err  = 0;
        was_pend = m_pend;
        if (we && addr < 4'd8 && !was_pend) m_sh[int'(addr)] = data;
        last = (m_pix == htot * m_act[7] - 1);
        if (!new_en) begin
            m_pix = 0;
            m_pend = 0;
        end else if (m_en) begin
            if (commit && !was_pend) begin
                if (axis_ok(m_sh[0], m_sh[1], m_sh[2], m_sh[3]) && axis_ok(m_sh[4], m_sh[5], m_sh[6], m_sh[7]))
                    m_pend = 1;
                else
                    m_err = 1;
            end
            if (last) begin
                m_pix = 0;
                if (was_pend) begin
                    m_act = m_sh;
                    m_pend = 0;
                end
            end else begin
                m_pix++;
            end
        end
        m_en = new_en; m_hpol = new_hp; m_vpol = new_vp;
    endtask

    task automatic cycle(input bit we, input logic [3:0] addr, input int data, input bit commit);
        cfg_we = we; cfg_addr = addr; cfg_wdata = W'(data); cfg_commit = commit;
        @(posedge pixclk);
        model_step(we, addr, data, commit);
        #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge pixclk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec() !== 28'h0) begin
            n_bad++; $display("FAIL reset_state got=%h want=0", dut_vec());
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (dut_vec() !== model_vec() || frame_start !== 1'b1) begin
            n_bad++; $display("FAIL reset_first_cycle got=%h want=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_default_run();
        int fs_n = 0, de_n = 0, hs_n = 0, vs_n = 0;
        repeat (2 * HT * VT) begin
            cycle(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL default_run t=%0t got=%h want=%h", $time, dut_vec(), model_vec());
            end
            fs_n += int'(frame_start); de_n += int'(DrawArea);
            hs_n += int'(!hSync);      vs_n += int'(!vSync);
        end
        n_cmp++;
        if (fs_n != 2 || de_n != 2 * HA * VA || hs_n != 2 * VT * (HSE - HSS) || vs_n != 2 * HT * (VSE - VSS)) begin
            n_bad++;
            $display("FAIL default_counts got fs=%0d de=%0d hs=%0d vs=%0d want fs=2 de=%0d hs=%0d vs=%0d",
                     fs_n, de_n, hs_n, vs_n, 2 * HA * VA, 2 * VT * (HSE - HSS), 2 * HT * (VSE - VSS));
        end
    endtask

    task automatic test_bad_commit();
        cycle(1, 4'd2, HSS - 1, 0);
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0 || dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL bad_commit_err got err=%b busy=%b want err=1 busy=0", cfg_err, cfg_busy);
        end
        cycle(1, 4'd2, HSE, 0);
        n_cmp++;
        if (cfg_err !== 1'b0 || cfg_busy !== 1'b0) begin
            n_bad++; $display("FAIL bad_commit_pulse got err=%b busy=%b want 0 0", cfg_err, cfg_busy);
        end
        repeat (HT * VT) begin
            cycle(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL bad_commit_timing got=%h want=%h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_enable();
        int k = 0;
        while ((m_pix % HT) != 5 || m_pix < HT) begin
            if (k++ > 2 * HT * VT) break;
            cycle(0, 0, 0, 0);
        end
        cycle(1, 4'd8, 0, 0);
        n_cmp++;
        if (CounterX !== '0 || CounterY !== '0 || DrawArea !== 1'b0 || hSync !== 1'b1 || vSync !== 1'b1) begin
            n_bad++; $display("FAIL disable got x=%0d y=%0d de=%b hs=%b vs=%b want 0 0 0 1 1",
                              CounterX, CounterY, DrawArea, hSync, vSync);
        end
        repeat (3) begin
            cycle(0, 0, 0, 1);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL idle_hold got=%h want=%h", dut_vec(), model_vec());
            end
        end
        cycle(1, 4'd8, 1, 0);
        n_cmp++;
        if (CounterX !== '0 || CounterY !== '0 || frame_start !== 1'b0) begin
            n_bad++; $display("FAIL enable_restart got x=%0d y=%0d fs=%b want 0 0 0", CounterX, CounterY, frame_start);
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (frame_start !== 1'b1 || CounterX !== 11'd1 || dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL enable_fstart got fs=%b x=%0d want fs=1 x=1", frame_start, CounterX);
        end
    endtask

    task automatic test_polarity();
        int k = 0, hs_n = 0, vs_n = 0;
        while ((m_pix % HT) != HSS + 1) begin
            if (k++ > 2 * HT) break;
            cycle(0, 0, 0, 0);
        end
        n_cmp++;
        if (hSync !== 1'b0) begin
            n_bad++; $display("FAIL pol_low got hs=%b want 0", hSync);
        end
        cycle(1, 4'd8, 7, 0);
        n_cmp++;
        if (hSync !== 1'b1 || dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL pol_invert got hs=%b vec=%h want hs=1 vec=%h", hSync, dut_vec(), model_vec());
        end
        repeat (HT * VT) begin
            cycle(0, 0, 0, 0);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL pol_run got=%h want=%h", dut_vec(), model_vec());
            end
            hs_n += int'(hSync); vs_n += int'(vSync);
        end
        n_cmp++;
        if (hs_n != VT * (HSE - HSS) || vs_n != HT * (VSE - VSS)) begin
            n_bad++; $display("FAIL pol_width got hs=%0d vs=%0d want hs=%0d vs=%0d",
                              hs_n, vs_n, VT * (HSE - HSS), HT * (VSE - VSS));
        end
        cycle(1, 4'd8, 1, 0);
    endtask

    task automatic test_same_cycle();
        int k = 0;
        cycle(1, 4'd2, HSS, 0);
        cycle(1, 4'd2, HSE, 1);
        n_cmp++;
        if (cfg_busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_fix got busy=%b err=%b want 1 0", cfg_busy, cfg_err);
        end
        while (cfg_busy === 1'b1 && k < 2 * HT * VT) begin
            cycle(0, 0, 0, 0);
            k++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL same_cycle_pend got=%h want=%h", dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (cfg_busy !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_timeout got busy=%b want 0", cfg_busy);
        end
        cycle(1, 4'd1, HSE, 1);
        n_cmp++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
            n_bad++; $display("FAIL same_cycle_break got err=%b busy=%b want 1 0", cfg_err, cfg_busy);
        end
        cycle(1, 4'd1, HSS, 0);
    endtask

    task automatic test_commit();
        int k = 0, period = 0;
        wr_t cfg[8] = '{'{4'd3, 100}, '{4'd0, 80}, '{4'd1, 84}, '{4'd2, 92},
                        '{4'd7, 10},  '{4'd4, 7},  '{4'd5, 8},  '{4'd6, 9}};
        foreach (cfg[i]) cycle(1, cfg[i].a, cfg[i].d, 0);
        repeat (37) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        n_cmp++;
        if (cfg_busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL commit_busy got busy=%b err=%b want 1 0", cfg_busy, cfg_err);
        end
        cycle(1, 4'd3, 50, 0);
        while (cfg_busy === 1'b1 && k < 2 * HT * VT) begin
            cycle(0, 0, 0, 0);
            k++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL commit_pend got=%h want=%h", dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (cfg_busy !== 1'b0 || CounterX !== '0 || CounterY !== '0) begin
            n_bad++; $display("FAIL commit_boundary got busy=%b x=%0d y=%0d want 0 0 0", cfg_busy, CounterX, CounterY);
        end
        k = 0;
        while (frame_start !== 1'b1 && k < 10) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        do begin
            cycle(0, 0, 0, 0);
            period++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL commit_new_frame got=%h want=%h", dut_vec(), model_vec());
            end
        end while (frame_start !== 1'b1 && period < 1200);
        n_cmp++;
        if (period != 1000) begin
            n_bad++; $display("FAIL commit_period got=%0d want=1000", period);
        end
    endtask

    task automatic test_reset_mid_pend();
        int fs_n = 0;
        cycle(0, 0, 0, 1);
        repeat (50) cycle(0, 0, 0, 0);
        n_cmp++;
        if (cfg_busy !== 1'b1) begin
            n_bad++; $display("FAIL rst_pend_setup got busy=%b want 1", cfg_busy);
        end
        do_reset();
        n_cmp++;
        if (dut_vec() !== 28'h0) begin
            n_bad++; $display("FAIL rst_pend_state got=%h want=0", dut_vec());
        end
        repeat (HT * VT) begin
            cycle(0, 0, 0, 0);
            fs_n += int'(frame_start);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL rst_pend_run got=%h want=%h", dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (fs_n != 1) begin
            n_bad++; $display("FAIL rst_pend_frames got=%0d want=1", fs_n);
        end
    endtask

    task automatic test_random();
        wr_t q[$];
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (q.size() != 0) begin
                wr_t w;
                w = q.pop_front();
                cycle(1, w.a, w.d, r < 10);
            end else if (r < 2) begin
                int ha, hss, hse, ht, va, vss, vse, vt;
                ha = $urandom_range(1, 20); hss = ha + $urandom_range(1, 4);
                hse = hss + $urandom_range(1, 6); ht = hse + $urandom_range(0, 5);
                va = $urandom_range(1, 8); vss = va + $urandom_range(1, 2);
                vse = vss + $urandom_range(1, 2); vt = vse + $urandom_range(0, 2);
                q.push_back('{4'd0, ha});  q.push_back('{4'd1, hss});
                q.push_back('{4'd2, hse}); q.push_back('{4'd3, ht});
                q.push_back('{4'd4, va});  q.push_back('{4'd5, vss});
                q.push_back('{4'd6, vse}); q.push_back('{4'd7, vt});
                cycle(0, 0, 0, 0);
            end else if (r < 5) begin
                cycle(0, 0, 0, 1);
            end else if (r < 7) begin
                cycle(1, 4'd8, int'($urandom_range(0, 3) << 1) | (($urandom_range(0, 19) != 0) ? 1 : 0), 0);
            end else if (r < 15) begin
                cycle(1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 40)), r < 9);
            end else begin
                cycle(0, 0, 0, 0);
            end
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL random i=%0d got=%h want=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_default_timing();
        logic [27:0] want;
        int p, hs_n = 0;
        do_reset();
        for (int k = 1; k <= 2500; k++) begin
            cycle(0, 0, 0, 0);
            p = k - 1;
            want = {W'(k % 800), W'(k / 800), !((p % 800) >= 656 && (p % 800) < 752), 1'b1,
                    ((p % 800) < 640) && ((p / 800) < 480), p == 0, 1'b0, 1'b0};
            if (k <= 800) hs_n += int'(!d_hs);
            n_cmp++;
            if ({d_x, d_y, d_hs, d_vs, d_draw, d_fs, d_busy, d_err} !== want) begin
                n_bad++; $display("FAIL default_640 k=%0d got=%h want=%h", k,
                                  {d_x, d_y, d_hs, d_vs, d_draw, d_fs, d_busy, d_err}, want);
            end
        end
        n_cmp++;
        if (hs_n != 96) begin
            n_bad++; $display("FAIL default_640_hwidth got=%0d want=96", hs_n);
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_bad_commit();
        test_enable();
        test_polarity();
        test_same_cycle();
        test_commit();
        test_reset_mid_pend();
        do_reset();
        test_random();
        test_default_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
